// File: rtl/el2_pkg.sv
// el2_pkg: shared types for the DCCM arbiter slice.
// Core parameter bundle and the read-return FSM state type.
package el2_pkg;

  typedef struct packed {
    logic [7:0] DCCM_BITS;
    logic [7:0] DCCM_FDATA_WIDTH;
  } el2_param_t;

  // Mirrors the el2_param.vh defaults for a 64KB DCCM with 7-bit ECC.
  localparam el2_param_t EL2_PARAM_DEFAULT = '{
    DCCM_BITS:        8'd16,
    DCCM_FDATA_WIDTH: 8'd39
  };

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RD_LSU = 2'b01,
    RD_DMA = 2'b10
  } el2_dccm_arb_state_t;

endpackage

// File: rtl/el2_dccm_arb_if.sv
// el2_dccm_arb_if: one requester's DCCM access handshake.
// Requester holds req/wr/addr/wdata until gnt.
interface el2_dccm_arb_if
  import el2_pkg::*;
#(
  parameter el2_param_t pt = EL2_PARAM_DEFAULT
) ();

  logic                            req;
  logic                            wr;
  logic [pt.DCCM_BITS-1:0]         addr;
  logic [pt.DCCM_FDATA_WIDTH-1:0]  wdata;
  logic                            gnt;

  modport master (
    output req, wr, addr, wdata,
    input  gnt
  );

  modport slave (
    input  req, wr, addr, wdata,
    output gnt
  );

  modport mon (
    input req, gnt
  );

endinterface

// File: rtl/el2_dccm_arb_starve.sv
// el2_dccm_arb_starve: DMA starvation counter, saturating at STARVE_MAX.
// Raises starve when DMA has waited STARVE_MAX cycles.
module el2_dccm_arb_starve #(
  parameter int STARVE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_l,
  el2_dccm_arb_if.mon dma,
  output logic       starve
);

  localparam logic [7:0] MAX = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;

  assign starve = dma.req & (starve_cnt == MAX);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      starve_cnt <= '0;
    end else if (!dma.req || dma.gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MAX) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/el2_dccm_arb.sv
// el2_dccm_arb: LSU/DMA arbiter for the DCCM with 1-cycle read return.
// Define EL2_DCCM_ARB_STARVE_EN to enable the DMA anti-starvation grant.
module el2_dccm_arb
  import el2_pkg::*;
#(
  parameter el2_param_t pt         = EL2_PARAM_DEFAULT,
  parameter int         STARVE_MAX = 15
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           lsu_req,
  input  logic                           lsu_wr,
  input  logic [pt.DCCM_BITS-1:0]        lsu_addr,
  input  logic [pt.DCCM_FDATA_WIDTH-1:0] lsu_wdata,
  output logic                           lsu_gnt,
  input  logic                           dma_req,
  input  logic                           dma_wr,
  input  logic [pt.DCCM_BITS-1:0]        dma_addr,
  input  logic [pt.DCCM_FDATA_WIDTH-1:0] dma_wdata,
  output logic                           dma_gnt,
  output logic                           lsu_rd_vld,
  output logic                           dma_rd_vld,
  output logic [pt.DCCM_FDATA_WIDTH-1:0] rd_data,
  output logic                           dccm_rden,
  output logic                           dccm_wren,
  output logic [pt.DCCM_BITS-1:0]        dccm_addr,
  output logic [pt.DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
  input  logic [pt.DCCM_FDATA_WIDTH-1:0] dccm_rd_data,
  output logic                           dma_starve
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("el2_dccm_arb: STARVE_MAX must be 1..255");
  end

  el2_dccm_arb_if #(.pt(pt)) lsu_bus ();
  el2_dccm_arb_if #(.pt(pt)) dma_bus ();

  assign lsu_bus.req   = lsu_req;
  assign lsu_bus.wr    = lsu_wr;
  assign lsu_bus.addr  = lsu_addr;
  assign lsu_bus.wdata = lsu_wdata;
  assign dma_bus.req   = dma_req;
  assign dma_bus.wr    = dma_wr;
  assign dma_bus.addr  = dma_addr;
  assign dma_bus.wdata = dma_wdata;

  logic starve;

`ifdef EL2_DCCM_ARB_STARVE_EN
  el2_dccm_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst_l (rst_l),
    .dma   (dma_bus.mon),
    .starve(starve)
  );
`else
  assign starve = 1'b0;
`endif

  // Gating with rst_l drops the combinational grants during reset.
  assign lsu_bus.gnt = rst_l & lsu_bus.req & ~starve;
  assign dma_bus.gnt = rst_l & dma_bus.req
                     & (~lsu_bus.req | starve);

  assign lsu_gnt    = lsu_bus.gnt;
  assign dma_gnt    = dma_bus.gnt;
  assign dma_starve = rst_l & starve;

  assign dccm_wren = (lsu_bus.gnt & lsu_bus.wr)
                   | (dma_bus.gnt & dma_bus.wr);
  assign dccm_rden = (lsu_bus.gnt & ~lsu_bus.wr)
                   | (dma_bus.gnt & ~dma_bus.wr);

  always_comb begin
    dccm_addr    = '0;
    dccm_wr_data = '0;
    unique case (1'b1)
      lsu_bus.gnt: begin
        dccm_addr    = lsu_bus.addr;
        dccm_wr_data = lsu_bus.wdata;
      end
      dma_bus.gnt: begin
        dccm_addr    = dma_bus.addr;
        dccm_wr_data = dma_bus.wdata;
      end
      default: ;
    endcase
  end

  el2_dccm_arb_state_t state, state_d;

  always_comb begin
    state_d = IDLE;
    if (lsu_bus.gnt && !lsu_bus.wr) begin
      state_d = RD_LSU;
    end else if (dma_bus.gnt && !dma_bus.wr) begin
      state_d = RD_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  assign lsu_rd_vld = (state == RD_LSU);
  assign dma_rd_vld = (state == RD_DMA);
  assign rd_data    = (state != IDLE) ? dccm_rd_data : '0;

endmodule

// File: doc/el2_dccm_arb.md
EL2_DCCM_ARB -- requirements
Module: el2_dccm_arb

Interface
REQ-001 SHALL take parameter pt, default el2_param_t set from el2_param.vh, supplying DCCM_BITS and DCCM_FDATA_WIDTH.
REQ-002 SHALL take parameter STARVE_MAX, default 15, giving the DMA starvation threshold in cycles (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single core clock.
REQ-004 SHALL have port rst_l, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have LSU request ports:
- lsu_req, input, 1 bit: request.
- lsu_wr, input, 1 bit: 1 = write.
- lsu_addr, input, pt.DCCM_BITS bits: address.
- lsu_wdata, input, pt.DCCM_FDATA_WIDTH bits: write data with ECC.
- lsu_gnt, output, 1 bit: grant.
REQ-006 SHALL have DMA request ports dma_req, dma_wr, dma_addr, dma_wdata and dma_gnt, with the same directions and widths as the LSU ports.
REQ-007 SHALL have read-return ports:
- lsu_rd_vld, dma_rd_vld: output, 1 bit each.
- rd_data: output, pt.DCCM_FDATA_WIDTH bits.
REQ-008 SHALL have DCCM-side ports:
- dccm_rden, dccm_wren: output, 1 bit each.
- dccm_addr: output, pt.DCCM_BITS bits.
- dccm_wr_data: output, pt.DCCM_FDATA_WIDTH bits.
- dccm_rd_data: input, pt.DCCM_FDATA_WIDTH bits.
REQ-009 SHALL have port dma_starve, output, 1 bit: forced DMA grant is active this cycle.

Function
REQ-010 Handshake rules:
- A requester holds req, wr, addr and wdata stable until it sees gnt.
- gnt is combinational, 1 cycle per access.
- At most one of lsu_gnt and dma_gnt SHALL be high in any cycle.
REQ-011 Priority: LSU wins when both request, except when a forced DMA grant is active (REQ-015).
REQ-012 On any grant, dccm_addr and dccm_wr_data SHALL take the winner's values in the same cycle.
- dccm_wren = gnt & wr; dccm_rden = gnt & ~wr.
- With no grant, both enables SHALL be 0 and the addr/data outputs SHALL be 0.
REQ-013 Read latency SHALL be 1 cycle.
- A return FSM has states IDLE, RD_LSU and RD_DMA.
- A granted read moves the FSM to the matching RD_* state on the next edge.
- While in RD_x, x_rd_vld = 1 and rd_data = dccm_rd_data; otherwise both rd_vld = 0 and rd_data = 0.
REQ-014 Back-to-back reads SHALL be supported:
- RD_x goes directly to RD_y when a new read is granted.
- RD_x goes to IDLE when no read is granted.
REQ-015 Starvation counter starve_cnt is 8 bits:
- Increments when dma_req & ~dma_gnt, saturating at STARVE_MAX.
- Clears to 0 when dma_gnt is high or dma_req is low.
- When starve_cnt == STARVE_MAX and dma_req is high, DMA SHALL be granted regardless of lsu_req, and dma_starve = 1 for that cycle.
REQ-016 A simultaneous LSU write and DMA read SHALL be resolved by REQ-011/015 only; the loser sees no grant and holds its request.

Reset
REQ-017 On rst_l low:
- The FSM SHALL go to IDLE and starve_cnt to 0.
- All grant, valid and enable outputs SHALL be 0 asynchronously.
REQ-018 A read granted in the cycle reset asserts SHALL produce no rd_vld after reset is released.

Configuration
REQ-019 With macro EL2_DCCM_ARB_STARVE_EN defined, REQ-015 SHALL be implemented.
REQ-020 Without EL2_DCCM_ARB_STARVE_EN, the arbiter SHALL be strict LSU priority; starve_cnt SHALL be absent and dma_starve tied to 0.

Structure
REQ-021 The return-FSM state enum el2_dccm_arb_state_t SHALL live in el2_pkg.
REQ-022 The starvation counter SHALL be a sub-module el2_dccm_arb_starve, instantiated only under EL2_DCCM_ARB_STARVE_EN.

Verification
REQ-023 LSU read only, addr 0x10, dccm_rd_data 0x1234 in the next cycle -> lsu_gnt=1 and dccm_rden=1 in cycle 0; lsu_rd_vld=1 with rd_data=0x1234 in cycle 1.
REQ-024 lsu_req and dma_req both high with macro off, LSU requesting for 40 cycles -> dma_gnt=0 throughout, then dma_gnt=1 in the first cycle lsu_req is low.
REQ-025 Same stimulus as REQ-024 with macro on and STARVE_MAX=15 -> dma_gnt=1 and dma_starve=1 in cycle 15; lsu_gnt=0 that cycle; starve_cnt returns to 0.
REQ-026 LSU read at cycle 0, DMA read at cycle 1 -> lsu_rd_vld in cycle 1 and dma_rd_vld in cycle 2, no idle gap, with the correct data routed to each.
REQ-027 rst_l pulsed low mid-cycle after a DMA read grant -> all outputs drop to 0 immediately; no dma_rd_vld after release.
REQ-028 LSU write 0x55 to addr 0x20 -> dccm_wren=1, dccm_wr_data=0x55 and dccm_addr=0x20 in the grant cycle; no rd_vld follows.
